csa_accumulator: RTL and testbench
==================================

// Module: csa_accumulator
// PURPOSE
//  Multi-operand accumulator built on the fulladder/CSA carry-save principle, parametrised in operand width.
//  Accepts a stream of WIDTH-bit operands, one per handshake beat.
//  Keeps the running total in redundant form (sum + carry vectors), so per-beat timing is one full-adder deep.
//  Runs a single carry-propagate addition only when the batch closes.
//  Sits between an operand source (valid/ready) and a result consumer (valid/ready).
// PARAMETERS
//  WIDTH   4   operand width in bits
//  CNT_W   4   batch counter width; exact result for up to 2**CNT_W-1 operands
//  ACC_W   WIDTH+CNT_W (derived localparam, not overridable)   accumulator/result width
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept an operand
//  in_data    in   WIDTH  operand, unsigned
//  in_last    in   1      qualifies in_valid: this beat closes the batch
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  ACC_W  batch sum, modulo 2**ACC_W
//  out_count  out  CNT_W  operands in batch, saturating at 2**CNT_W-1
//  out_ovf    out  1      batch had more than 2**CNT_W-1 operands
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state <= ACCUM; S, C, count, ovf, out_sum <= 0; out_valid <= 0.
//   - Applies from any state, including mid-batch and mid-resolve; the partial batch is discarded.
//  Handshake:
//   - An input beat transfers when in_valid & in_ready; a result transfers when out_valid & out_ready.
//   - out_* are stable while out_valid=1 and out_ready=0.
//  States:
//   - ACCUM: in_ready=1, out_valid=0. On each input beat:
//       S <= S ^ C ^ D;  C <= maj(S,C,D) << 1, truncated to ACC_W.
//       D = zero-extended in_data.
//     count <= count+1, saturating at 2**CNT_W-1.
//     ovf <= ovf | (count == 2**CNT_W-1), sticky within the batch.
//     If in_last is set on the beat: -> RESOLVE.
//   - RESOLVE: in_ready=0. out_sum <= S + C (ACC_W carry-propagate adder, modulo 2**ACC_W).
//     -> HOLD.
//   - HOLD: in_ready=0, out_valid=1; out_count=count, out_ovf=ovf.
//     On a result transfer: S, C, count, ovf <= 0, -> ACCUM; in_ready rises the next cycle.
//  Timing and throughput:
//   - Latency: last beat accepted at edge N -> out_valid=1 in the cycle after edge N+1 (2 cycles).
//   - Throughput: 1 operand/cycle inside a batch; 2 dead input cycles per batch plus any HOLD stall.
//  Boundary conditions:
//   - A single-operand batch (in_last on the first beat) is legal and gives out_sum=in_data, out_count=1.
//   - in_valid/in_data/in_last are ignored outside ACCUM.
//   - in_last without in_valid has no effect.
//   - Arithmetic is exact while count <= 2**CNT_W-1; beyond that, the sum wraps mod 2**ACC_W and out_ovf=1.
// CONFIGURATION
//  CSA_ACC_CPA_PIPE_EN:
//   - Defined: RESOLVE takes 2 cycles.
//       Cycle 1 adds the low ACC_W/2 bits and registers the carry-out.
//       Cycle 2 adds the high bits plus the registered carry.
//     Latency becomes 3 cycles and the dead input cycles per batch become 3.
//     Reset during either half aborts the addition.
//   - Undefined: single-cycle RESOLVE as above.
// TESTING
//  1. 15,15,15 (last on 3rd), out_ready=1 -> out_sum=45, out_count=3, out_ovf=0, out_valid 2 cycles after last beat.
//  2. Single beat 9 with in_last -> out_sum=9, out_count=1, out_ovf=0.
//  3. 18 beats of 15 -> out_sum=14 (270 mod 256), out_count=15, out_ovf=1.
//  4. Hold out_ready=0 for 5 cycles after out_valid -> out_sum/out_count stable, in_ready=0, in_valid pulses ignored.
//     Then out_ready=1 -> in_ready=1 next cycle.
//  5. rst after 2 beats (7,8) -> all outputs 0; then new batch 3,4 (last) -> out_sum=7, out_count=2.
//  6. With CSA_ACC_CPA_PIPE_EN: repeat 1 and 3 -> same values, out_valid 3 cycles after last beat.
//     Also assert rst in RESOLVE -> out_valid stays 0.

Source files
------------

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save multi-operand accumulator with valid/ready in and out.
// Optional macro CSA_ACC_CPA_PIPE_EN splits the final carry-propagate add over two cycles.
module csa_accumulator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+CNT_W-1:0] out_sum,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_ovf
);
  localparam int ACC_W = WIDTH + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {ACCUM, RESOLVE, RESOLVE2, HOLD} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d, d;
  logic [CNT_W-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
`ifdef CSA_ACC_CPA_PIPE_EN
  localparam int HALF = ACC_W / 2;
  localparam int HI = ACC_W - HALF;
  logic [HALF-1:0] lo_q, lo_d;
  logic cy_q, cy_d;
`endif
  assign d = ACC_W'(in_data);
  assign in_ready = state_q == ACCUM;
  assign out_valid = state_q == HOLD;
  assign out_sum = sum_q;
  assign out_count = count_q;
  assign out_ovf = ovf_q;
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    c_d = c_q;
    count_d = count_q;
    ovf_d = ovf_q;
    sum_d = sum_q;
`ifdef CSA_ACC_CPA_PIPE_EN
    lo_d = lo_q;
    cy_d = cy_q;
`endif
    if (state_q == ACCUM && in_valid) begin
      s_d = s_q ^ c_q ^ d;
      c_d = ((s_q & c_q) | (s_q & d) | (c_q & d)) << 1;
      count_d = count_q == CNT_MAX ? count_q : count_q + 1'b1;
      ovf_d = ovf_q | (count_q == CNT_MAX);
      state_d = in_last ? RESOLVE : ACCUM;
    end else if (state_q == RESOLVE) begin
`ifdef CSA_ACC_CPA_PIPE_EN
      {cy_d, lo_d} = {1'b0, s_q[HALF-1:0]} + {1'b0, c_q[HALF-1:0]};
      state_d = RESOLVE2;
`else
      sum_d = s_q + c_q;
      state_d = HOLD;
`endif
    end else if (state_q == RESOLVE2) begin
`ifdef CSA_ACC_CPA_PIPE_EN
      sum_d = {s_q[ACC_W-1:HALF] + c_q[ACC_W-1:HALF] + HI'(cy_q), lo_q};
`endif
      state_d = HOLD;
    end else if (state_q == HOLD && out_ready) begin
      s_d = '0;
      c_d = '0;
      count_d = '0;
      ovf_d = 1'b0;
      state_d = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q <= '0;
      c_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      sum_q <= '0;
`ifdef CSA_ACC_CPA_PIPE_EN
      lo_q <= '0;
      cy_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      c_q <= c_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      sum_q <= sum_d;
`ifdef CSA_ACC_CPA_PIPE_EN
      lo_q <= lo_d;
      cy_q <= cy_d;
`endif
    end
  end
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: directed checks of batch sums, saturation, back-pressure and reset.
module tb_csa_accumulator;
`ifdef CSA_ACC_CPA_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic in_ready, out_valid, out_ovf;
  logic [3:0] in_data = 0, out_count;
  logic [7:0] out_sum;
  int passed = 0, total = 0, cyc;
  csa_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic send(input logic [3:0] dat, input logic last);
    in_valid = 1;
    in_data = dat;
    in_last = last;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic wait_result();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 40);
    check("latency", cyc, LAT);
  endtask
  task automatic drain();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    send(15, 0); send(15, 0); send(15, 1);
    wait_result();
    check("t1_sum", out_sum, 45);
    check("t1_count", out_count, 3);
    check("t1_ovf", out_ovf, 0);
    drain();
    in_last = 1;
    @(posedge clk);
    #1 in_last = 0;
    @(negedge clk);
    check("last_no_valid_ready", in_ready, 1);
    check("last_no_valid_count", out_count, 0);
    send(9, 1);
    wait_result();
    check("t2_sum", out_sum, 9);
    check("t2_count", out_count, 1);
    check("t2_ovf", out_ovf, 0);
    drain();
    for (int i = 0; i < 18; i++) send(15, i == 17);
    wait_result();
    check("t3_sum", out_sum, 14);
    check("t3_count", out_count, 15);
    check("t3_ovf", out_ovf, 1);
    drain();
    out_ready = 0;
    send(5, 0); send(6, 1);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 1; in_last = 1;
      @(negedge clk);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_sum", out_sum, 11);
      check("t4_hold_count", out_count, 2);
      check("t4_hold_ready", in_ready, 0);
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    @(negedge clk);
    check("t4_ready_back", in_ready, 1);
    check("t4_valid_drop", out_valid, 0);
    send(2, 1);
    wait_result();
    check("t4_next_sum", out_sum, 2);
    check("t4_next_count", out_count, 1);
    drain();
    send(7, 0); send(8, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_out_sum", out_sum, 0);
    check("t5_out_count", out_count, 0);
    check("t5_out_ovf", out_ovf, 0);
    send(3, 0); send(4, 1);
    wait_result();
    check("t5_sum", out_sum, 7);
    check("t5_count", out_count, 2);
    drain();
    send(1, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_rst_resolve_valid", out_valid, 0);
    end
    check("t6_rst_resolve_sum", out_sum, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
